// File: rtl/gcd_feeder_if.sv
// Handshake bundle between the GCD feeder, its operand producer, the GCD engine
// and the result consumer. The feeder uses the slave view.
`timescale 1ns/1ps
interface gcd_feeder_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_a;
  logic [31:0] in_b;
  logic        gcd_start;
  logic [31:0] gcd_a;
  logic [31:0] gcd_b;
  logic        gcd_ready;
  logic        gcd_done;
  logic [31:0] gcd_result;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_a;
  logic [31:0] out_b;
  logic [31:0] out_gcd;
  logic        out_err;
  logic        busy;

  modport slave (
    input  in_valid, in_a, in_b, gcd_ready, gcd_done, gcd_result, out_ready,
    output in_ready, gcd_start, gcd_a, gcd_b, out_valid, out_a, out_b, out_gcd,
           out_err, busy
  );

  modport master (
    output in_valid, in_a, in_b, gcd_ready, gcd_done, gcd_result, out_ready,
    input  in_ready, gcd_start, gcd_a, gcd_b, out_valid, out_a, out_b, out_gcd,
           out_err, busy
  );
endinterface

// File: rtl/gcd_feeder.sv
// Operand FIFO feeding an external GCD engine one job at a time; rejects
// all-zero or negative pairs without engaging the engine.
`timescale 1ns/1ps
module gcd_feeder #(
    parameter int unsigned DEPTH = 4
) (
    input  logic         clk,
    input  logic         reset,
    gcd_feeder_if.slave  bus
);
    localparam int unsigned AW = $clog2(DEPTH);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, HOLD} state_t;

    state_t      state_q, state_d;
    logic [31:0] fa_q [DEPTH];
    logic [31:0] fb_q [DEPTH];
    logic [AW:0] wr_q, rd_q;
    logic [31:0] a_q, a_d, b_q, b_d, res_q, res_d;
    logic        err_q, err_d;
    logic        full, empty, push, pop;
    logic        start, valid;
    logic [31:0] head_a, head_b;
    logic        reject;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    assign empty  = (wr_q == rd_q);
    assign full   = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
    assign push   = bus.in_valid && !full;
    assign head_a = fa_q[rd_q[AW-1:0]];
    assign head_b = fb_q[rd_q[AW-1:0]];
    assign reject = ((head_a == '0) && (head_b == '0)) ||
                    ($signed(head_a) < 0) || ($signed(head_b) < 0);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_q <= '0;
            rd_q <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                fa_q[i] <= '0;
                fb_q[i] <= '0;
            end
        end else begin
            if (push) begin
                fa_q[wr_q[AW-1:0]] <= bus.in_a;
                fb_q[wr_q[AW-1:0]] <= bus.in_b;
                wr_q <= wr_q + 1'b1;
            end
            if (pop) begin
                rd_q <= rd_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        res_d   = res_q;
        err_d   = err_q;
        pop     = 1'b0;
        start   = 1'b0;
        valid   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (!empty) begin
                    pop = 1'b1;
                    a_d = head_a;
                    b_d = head_b;
                    if (reject) begin
                        err_d   = 1'b1;
                        res_d   = '0;
                        state_d = HOLD;
                    end else begin
                        state_d = ISSUE;
                    end
                end
            end
            ISSUE: begin
                start = bus.gcd_ready;
                if (bus.gcd_ready) state_d = WAIT;
            end
            WAIT: begin
                if (bus.gcd_done) begin
                    res_d   = bus.gcd_result;
                    err_d   = 1'b0;
                    state_d = HOLD;
                end
            end
            HOLD: begin
                valid = 1'b1;
                if (bus.out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.in_ready  = !full;
    assign bus.gcd_start = start;
    assign bus.gcd_a     = a_q;
    assign bus.gcd_b     = b_q;
    assign bus.out_valid = valid;
    assign bus.out_a     = a_q;
    assign bus.out_b     = b_q;
    assign bus.out_gcd   = res_q;
    assign bus.out_err   = err_q;
    assign bus.busy      = (state_q != IDLE) || !empty;
endmodule

// File: tb/tb_gcd_feeder.sv
// Directed bench for gcd_feeder: single job, rejection, backpressure, output
// stall, spurious completion and mid-job reset.
`timescale 1ns/1ps
module tb_gcd_feeder;
  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  gcd_feeder_if bus();

  gcd_feeder #(.DEPTH(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] g;
    logic        e;
  } rec_t;

  int   total = 0;
  int   bad = 0;
  int   start_cnt = 0;
  int   ov_cycles = 0;
  rec_t q[$];

  logic        eng_auto = 1'b0;
  logic        eng_done = 1'b0;
  logic        man_done = 1'b0;
  logic [31:0] eng_res = '0;
  logic [31:0] man_res = '0;

  assign bus.gcd_done   = eng_done | man_done;
  assign bus.gcd_result = man_done ? man_res : eng_res;

  function automatic logic [31:0] gcd(input logic [31:0] a, input logic [31:0] b);
    logic [31:0] t;
    while (b != 0) begin
      t = a % b;
      a = b;
      b = t;
    end
    return a;
  endfunction

  // Mid-cycle monitor: start pulses, out_valid cycles, accepted records.
  always begin
    rec_t r;
    @(negedge clk);
    #2;
    if (bus.gcd_start === 1'b1) start_cnt++;
    if (bus.out_valid === 1'b1) ov_cycles++;
    if (bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
      r.a = bus.out_a;
      r.b = bus.out_b;
      r.g = bus.out_gcd;
      r.e = bus.out_err;
      q.push_back(r);
    end
  end

  // Engine model: answers 5 cycles after a start pulse.
  initial begin
    logic [31:0] ea, eb;
    forever begin
      @(negedge clk);
      #2;
      if (eng_auto && bus.gcd_start === 1'b1) begin
        ea = bus.gcd_a;
        eb = bus.gcd_b;
        repeat (5) @(negedge clk);
        eng_res  = gcd(ea, eb);
        eng_done = 1'b1;
        @(negedge clk);
        eng_done = 1'b0;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [31:0] a, input logic [31:0] b, input string tag);
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_a     = a;
    bus.in_b     = b;
    #1;
    for (int i = 0; i < 300 && bus.in_ready !== 1'b1; i++) begin
      @(negedge clk);
      #1;
    end
    chk({tag, ".acc"}, 32'(bus.in_ready), 32'd1);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_out(input int n, input string tag);
    for (int i = 0; i < 400 && q.size() < n; i++) begin
      @(negedge clk);
      #1;
    end
    chk({tag, ".cnt"}, 32'(q.size()), 32'(n));
  endtask

  task automatic chk_rec(input int idx, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] g, input logic e, input string tag);
    rec_t r;
    r = (idx < q.size()) ? q[idx] : '0;
    chk({tag, ".a"}, r.a, a);
    chk({tag, ".b"}, r.b, b);
    chk({tag, ".g"}, r.g, g);
    chk({tag, ".e"}, 32'(r.e), 32'(e));
  endtask

  initial begin
    int s0, n0, ov0, bad_cyc;
    logic [31:0] xa [6];
    logic [31:0] xb [6];
    logic [31:0] xg [6];

    bus.in_valid  = 1'b0;
    bus.in_a      = '0;
    bus.in_b      = '0;
    bus.gcd_ready = 1'b0;
    bus.out_ready = 1'b0;

    // Reset state
    #12;
    chk("rst.in_ready", 32'(bus.in_ready), 32'd1);
    chk("rst.out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst.gcd_start", 32'(bus.gcd_start), 32'd0);
    chk("rst.busy", 32'(bus.busy), 32'd0);
    chk("rst.out_a", bus.out_a, 32'd0);
    chk("rst.gcd_b", bus.gcd_b, 32'd0);
    @(negedge clk);
    reset = 1'b1;

    // Single job (48,18) -> 6
    bus.gcd_ready = 1'b1;
    bus.out_ready = 1'b1;
    eng_auto      = 1'b1;
    push(32'd48, 32'd18, "t1");
    @(negedge clk); #1;
    chk("t1.busy", 32'(bus.busy), 32'd1);
    chk("t1.nostart", 32'(bus.gcd_start), 32'd0);
    @(negedge clk); #1;
    chk("t1.start", 32'(bus.gcd_start), 32'd1);
    chk("t1.gcd_a", bus.gcd_a, 32'd48);
    chk("t1.gcd_b", bus.gcd_b, 32'd18);
    wait_out(1, "t1");
    chk_rec(0, 32'd48, 32'd18, 32'd6, 1'b0, "t1.rec");
    chk("t1.starts", 32'(start_cnt), 32'd1);
    chk("t1.ovcyc", 32'(ov_cycles), 32'd1);
    @(negedge clk); #1;
    chk("t1.idle", 32'(bus.busy), 32'd0);

    // Rejections
    s0 = start_cnt;
    push(32'd0, 32'd0, "t2a");
    @(negedge clk); #1;
    chk("t2.lat_lo", 32'(bus.out_valid), 32'd0);
    @(negedge clk); #1;
    chk("t2.lat_hi", 32'(bus.out_valid), 32'd1);
    chk("t2.err", 32'(bus.out_err), 32'd1);
    push(-32'sd4, 32'd6, "t2b");
    wait_out(3, "t2");
    chk_rec(1, 32'd0, 32'd0, 32'd0, 1'b1, "t2.r0");
    chk_rec(2, 32'hFFFF_FFFC, 32'd6, 32'd0, 1'b1, "t2.r1");
    chk("t2.starts", 32'(start_cnt), 32'(s0));

    // Backpressure and full
    xa = '{32'd12, 32'd9, 32'd7, 32'd20, 32'd0, 32'd100};
    xb = '{32'd18, 32'd6, 32'd5, 32'd0,  32'd9, 32'd75};
    xg = '{32'd6,  32'd3, 32'd1, 32'd20, 32'd9, 32'd25};
    bus.gcd_ready = 1'b0;
    s0 = start_cnt;
    n0 = q.size();
    for (int k = 0; k < 5; k++) push(xa[k], xb[k], $sformatf("t3.p%0d", k));
    @(negedge clk); #1;
    chk("t3.full", 32'(bus.in_ready), 32'd0);
    bus.in_valid = 1'b1;
    bus.in_a     = xa[5];
    bus.in_b     = xb[5];
    repeat (5) @(negedge clk);
    #1;
    chk("t3.still_full", 32'(bus.in_ready), 32'd0);
    chk("t3.nostart", 32'(start_cnt), 32'(s0));
    chk("t3.busy", 32'(bus.busy), 32'd1);
    bus.gcd_ready = 1'b1;
    for (int i = 0; i < 300 && bus.in_ready !== 1'b1; i++) begin
      @(negedge clk); #1;
    end
    chk("t3.p5.acc", 32'(bus.in_ready), 32'd1);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    wait_out(n0 + 6, "t3");
    for (int k = 0; k < 6; k++)
      chk_rec(n0 + k, xa[k], xb[k], xg[k], 1'b0, $sformatf("t3.r%0d", k));

    // Output stall on (12,8,4)
    bus.out_ready = 1'b0;
    n0 = q.size();
    s0 = start_cnt;
    push(32'd12, 32'd8, "t4");
    for (int i = 0; i < 300 && bus.out_valid !== 1'b1; i++) begin
      @(negedge clk); #1;
    end
    chk("t4.valid", 32'(bus.out_valid), 32'd1);
    bad_cyc = 0;
    repeat (10) begin
      @(negedge clk); #1;
      if (bus.out_valid !== 1'b1 || bus.out_a !== 32'd12 || bus.out_b !== 32'd8 ||
          bus.out_gcd !== 32'd4 || bus.out_err !== 1'b0)
        bad_cyc++;
    end
    chk("t4.stable", 32'(bad_cyc), 32'd0);
    push(32'd15, 32'd10, "t4.p1");
    push(32'd8,  32'd12, "t4.p2");
    push(32'd21, 32'd14, "t4.p3");
    push(32'd3,  32'd3,  "t4.p4");
    @(negedge clk); #1;
    chk("t4.full", 32'(bus.in_ready), 32'd0);
    chk("t4.hold_gcd", bus.out_gcd, 32'd4);
    chk("t4.starts", 32'(start_cnt), 32'(s0 + 1));
    bus.out_ready = 1'b1;
    wait_out(n0 + 5, "t4");
    chk_rec(n0,     32'd12, 32'd8,  32'd4, 1'b0, "t4.r0");
    chk_rec(n0 + 1, 32'd15, 32'd10, 32'd5, 1'b0, "t4.r1");
    chk_rec(n0 + 2, 32'd8,  32'd12, 32'd4, 1'b0, "t4.r2");
    chk_rec(n0 + 3, 32'd21, 32'd14, 32'd7, 1'b0, "t4.r3");
    chk_rec(n0 + 4, 32'd3,  32'd3,  32'd3, 1'b0, "t4.r4");

    // Spurious done in IDLE, then reset during WAIT
    eng_auto = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    chk("t5.idle", 32'(bus.busy), 32'd0);
    n0  = q.size();
    ov0 = ov_cycles;
    @(negedge clk);
    man_res  = 32'd99;
    man_done = 1'b1;
    @(negedge clk);
    man_done = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    chk("t5.spur_valid", 32'(bus.out_valid), 32'd0);
    chk("t5.spur_busy", 32'(bus.busy), 32'd0);
    s0 = start_cnt;
    push(32'd35, 32'd14, "t5");
    for (int i = 0; i < 50 && start_cnt == s0; i++) begin
      @(negedge clk); #3;
    end
    chk("t5.started", 32'(start_cnt), 32'(s0 + 1));
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("t5.rst_busy", 32'(bus.busy), 32'd0);
    chk("t5.rst_valid", 32'(bus.out_valid), 32'd0);
    chk("t5.rst_in_ready", 32'(bus.in_ready), 32'd1);
    chk("t5.rst_gcd_a", bus.gcd_a, 32'd0);
    chk("t5.rst_start", 32'(bus.gcd_start), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    man_res  = 32'd7;
    man_done = 1'b1;
    @(negedge clk);
    man_done = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    chk("t5.post_valid", 32'(bus.out_valid), 32'd0);
    chk("t5.post_busy", 32'(bus.busy), 32'd0);
    chk("t5.post_in_ready", 32'(bus.in_ready), 32'd1);
    chk("t5.post_recs", 32'(q.size()), 32'(n0));
    chk("t5.post_ovcyc", 32'(ov_cycles), 32'(ov0));
    chk("t5.post_gcd", bus.out_gcd, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/gcd_feeder.md
GCD_FEEDER -- requirements
Module: gcd_feeder

Interface
REQ-001 Parameter DEPTH, default 4, operand FIFO depth; power of two, minimum 2.
REQ-002 clk  in  1  single clock; all state updates on the rising edge.
REQ-003 reset  in  1  asynchronous, active-low reset: clears all state while 0.
REQ-004 in_valid  in  1  operand pair offered.
REQ-005 in_ready  out  1  FIFO can accept the pair.
REQ-006 in_a, in_b  in  32 each  signed operands.
REQ-007 gcd_start  out  1  one-cycle start pulse to the GCD engine.
REQ-008 gcd_a, gcd_b  out  32 each  operands to the GCD engine.
REQ-009 gcd_ready  in  1  GCD engine idle.
REQ-010 gcd_done  in  1  GCD engine completion pulse.
REQ-011 gcd_result  in  32  GCD engine result; valid with gcd_done.
REQ-012 out_valid  out  1  result record available.
REQ-013 out_ready  in  1  consumer accepts the record.
REQ-014 out_a, out_b, out_gcd  out  32 each  original operands and their GCD.
REQ-015 out_err  out  1  pair rejected, not sent to the engine.
REQ-016 busy  out  1  FSM is not in IDLE, or the FIFO is not empty.

Function
REQ-017 FIFO behaviour:
- in_ready = !full.
- Push when in_valid && in_ready.
- When full, no push occurs, even in a cycle where a pop also occurs.
- Order of pairs is preserved.
REQ-018 The FSM has four states: IDLE, ISSUE, WAIT, HOLD.
REQ-019 IDLE with the FIFO non-empty:
- Pop the head into internal registers a_r, b_r in that cycle.
- If a rejection condition holds, go to HOLD with the error flag set to 1 and the result register set to 0.
- Otherwise, go to ISSUE.
REQ-020 Rejection conditions, tested as 32-bit signed values:
- both operands are 0; or
- either operand is negative.
REQ-021 ISSUE:
- gcd_start = gcd_ready, combinationally.
- When gcd_ready = 1, go to WAIT.
- gcd_start is 0 in every other state.
REQ-022 gcd_a = a_r and gcd_b = b_r, held stable from ISSUE through the end of WAIT.
REQ-023 WAIT:
- On gcd_done = 1, capture gcd_result into the result register and clear the error flag.
- Then go to HOLD.
REQ-024 gcd_done outside WAIT is ignored.
REQ-025 gcd_result is sampled only in the cycle where gcd_done = 1.
REQ-026 HOLD:
- out_valid = 1.
- out_a = a_r, out_b = b_r, out_gcd = result register, out_err = error flag.
- When out_ready = 1, go to IDLE.
REQ-027 Outputs stay stable while out_valid = 1 and out_ready = 0.
REQ-028 out_valid is 0 in every state except HOLD.
REQ-029 At most one job is in flight; the next pop occurs no earlier than the cycle after the HOLD handshake.
REQ-030 Best-case latency, from the push cycle of a pair into an empty FIFO with the FSM in IDLE:
- pop on the next edge;
- gcd_start 1 cycle later;
- out_valid in the cycle after gcd_done.
REQ-031 A rejected pair reaches out_valid 2 cycles after its push cycle and generates no gcd_start.
REQ-032 All arithmetic and comparisons are 32-bit signed.
- No width extension is applied to the result.
- gcd_result is forwarded unmodified.

Reset
REQ-033 When reset = 0, asynchronously force all of the following:
- FIFO empty; FSM to IDLE.
- a_r, b_r, result register and error flag to 0.
- in_ready = 1; out_valid = 0; gcd_start = 0; busy = 0.
- All data outputs to 0.
REQ-034 Reset mid-operation discards all queued and in-flight jobs.
- A gcd_done arriving after reset is released is ignored (FSM in IDLE).
REQ-035 Operation resumes on the first rising edge after reset returns to 1.

Verification
REQ-036 Single job:
- push (48,18); engine model returns 6 after 5 cycles; out_ready = 1.
- Required: exactly one gcd_start with gcd_a = 48, gcd_b = 18.
- Required: out record (48,18,6,err = 0); out_valid high for 1 cycle.
REQ-037 Rejection:
- push (0,0), then (-4,6).
- Required: two records (0,0,0,1) and (-4,6,0,1); zero gcd_start pulses.
REQ-038 Backpressure and full:
- hold gcd_ready = 0; push 6 pairs back-to-back.
- Required: in_ready drops after 5 accepted pairs (4 in the FIFO, 1 popped into a_r/b_r); the 6th waits.
- Required: after release, all pairs complete in push order.
REQ-039 Output stall:
- out_ready = 0 for 10 cycles while in HOLD with (12,8,4).
- Required: outputs remain stable; no new gcd_start; in_ready stays 1 until the FIFO fills.
REQ-040 Spurious and reset:
- pulse gcd_done while in IDLE → no output.
- assert reset during WAIT for (35,14), then deliver gcd_done = 1 with result 7 → out_valid stays 0, FIFO empty, busy = 0.
